vc_mem_arbiter: RTL and testbench

VC_MEM_ARBITER -- requirements
Module: vc_mem_arbiter

---
 rtl/vc_mem_arbiter.sv | 115 +++++++++++
 tb/tb_vc_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_mem_arbiter.sv
// Arbitrates between victim-cache write-backs and L2 miss fills for a single
// physical memory port. VC wins by default, but after two VC grants taken while
// L2 was also waiting, L2 gets the next grant so it cannot be starved.
module vc_mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         vc_req,
  input  logic [15:0]  vc_address,
  input  logic [127:0] vc_wdata,
  output logic         vc_mem_ack,
  input  logic         l2_mem_read,
  input  logic [15:0]  l2_address,
  output logic [127:0] l2_mem_rdata,
  output logic         l2_mem_ack,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned STREAK_W = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VC_WRITE = 2'd1,
    L2_READ  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [STREAK_W-1:0]   vc_streak_q, vc_streak_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  vc_wins;

  // VC has priority unless L2 is waiting and VC has already won twice in a row.
  assign vc_wins = vc_req && !(l2_mem_read && (vc_streak_q == STREAK_MAX));

  // State, fairness counter and captured transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vc_streak_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      vc_streak_q <= vc_streak_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state, grant capture and completion acks.
  always_comb begin
    state_d     = state_q;
    vc_streak_d = vc_streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    vc_mem_ack  = 1'b0;
    l2_mem_ack  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vc_wins) begin
          state_d = VC_WRITE;
          addr_d  = vc_address;
          wdata_d = vc_wdata;
          if (l2_mem_read) begin
            vc_streak_d = (vc_streak_q == STREAK_MAX) ? STREAK_MAX
                                                      : vc_streak_q + STREAK_W'(1);
          end else begin
            vc_streak_d = '0;
          end
        end else if (l2_mem_read) begin
          state_d     = L2_READ;
          addr_d      = l2_address;
          vc_streak_d = '0;
        end
      end
      VC_WRITE: begin
        if (pmem_resp) begin
          vc_mem_ack = 1'b1;
          state_d    = IDLE;
        end
      end
      L2_READ: begin
        if (pmem_resp) begin
          l2_mem_ack = 1'b1;
          rdata_d    = pmem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from registered state only; fill data bypasses on the ack cycle.
  always_comb begin
    pmem_write   = (state_q == VC_WRITE);
    pmem_read    = (state_q == L2_READ);
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    l2_mem_rdata = l2_mem_ack ? pmem_rdata : rdata_q;
  end

endmodule

// File: tb/tb_vc_mem_arbiter.sv
// Directed, table-driven bench for vc_mem_arbiter: one table row per clock cycle,
// plus a hand-written sequence for reset in the middle of a write-back.
module tb_vc_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         vc_req = 1'b0;
  logic [15:0]  vc_address = '0;
  logic [127:0] vc_wdata = '0;
  logic         vc_mem_ack;
  logic         l2_mem_read = 1'b0;
  logic [15:0]  l2_address = '0;
  logic [127:0] l2_mem_rdata;
  logic         l2_mem_ack;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] DDB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] W1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] W2  = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] R2  = 128'hCAFE_F00D_0000_FFFF_AAAA_5555_0101_1010;

  always #5 clk = ~clk;

  vc_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .vc_req       (vc_req),
    .vc_address   (vc_address),
    .vc_wdata     (vc_wdata),
    .vc_mem_ack   (vc_mem_ack),
    .l2_mem_read  (l2_mem_read),
    .l2_address   (l2_address),
    .l2_mem_rdata (l2_mem_rdata),
    .l2_mem_ack   (l2_mem_ack),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct {
    logic         rst;
    logic         vreq;
    logic [15:0]  vaddr;
    logic [127:0] vwd;
    logic         l2r;
    logic [15:0]  l2a;
    logic [127:0] prd;
    logic         presp;
    logic         e_rd;
    logic         e_wr;
    logic [15:0]  e_addr;
    logic [127:0] e_wd;
    logic         e_vack;
    logic         e_lack;
    logic [127:0] e_lrd;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  function automatic vec_t mk(
    input logic rst, input logic vreq, input logic [15:0] vaddr, input logic [127:0] vwd,
    input logic l2r, input logic [15:0] l2a, input logic [127:0] prd, input logic presp,
    input logic e_rd, input logic e_wr, input logic [15:0] e_addr, input logic [127:0] e_wd,
    input logic e_vack, input logic e_lack, input logic [127:0] e_lrd);
    vec_t v;
    v.rst = rst; v.vreq = vreq; v.vaddr = vaddr; v.vwd = vwd;
    v.l2r = l2r; v.l2a = l2a; v.prd = prd; v.presp = presp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_vack = e_vack; v.e_lack = e_lack; v.e_lrd = e_lrd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst;
    vc_req      = v.vreq;
    vc_address  = v.vaddr;
    vc_wdata    = v.vwd;
    l2_mem_read = v.l2r;
    l2_address  = v.l2a;
    pmem_rdata  = v.prd;
    pmem_resp   = v.presp;
  endtask

  task automatic check_outputs(input vec_t v, input int idx);
    chk("pmem_read",    idx, 128'(pmem_read),    128'(v.e_rd));
    chk("pmem_write",   idx, 128'(pmem_write),   128'(v.e_wr));
    chk("pmem_address", idx, 128'(pmem_address), 128'(v.e_addr));
    chk("pmem_wdata",   idx, pmem_wdata,         v.e_wd);
    chk("vc_mem_ack",   idx, 128'(vc_mem_ack),   128'(v.e_vack));
    chk("l2_mem_ack",   idx, 128'(l2_mem_ack),   128'(v.e_lack));
    chk("l2_mem_rdata", idx, l2_mem_rdata,       v.e_lrd);
  endtask

  initial begin
    //            rst vreq vaddr     vwd  l2r l2a       prd  resp | rd wr addr      wd   vack lack lrd
    vec[0]  = mk(1, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 0, 16'h0000, '0,  0, 0, '0);   // reset
    vec[1]  = mk(0, 1, 16'h1230, DA5, 0, 16'h0000, '0,  0,  0, 0, 16'h0000, '0,  0, 0, '0);   // VC req seen
    vec[2]  = mk(0, 1, 16'h1230, DA5, 0, 16'h0000, '0,  0,  0, 1, 16'h1230, DA5, 0, 0, '0);   // granted
    vec[3]  = mk(0, 1, 16'h9999, '0,  0, 16'h0000, '0,  0,  0, 1, 16'h1230, DA5, 0, 0, '0);   // addr held
    vec[4]  = mk(0, 1, 16'h9999, '0,  0, 16'h0000, '0,  0,  0, 1, 16'h1230, DA5, 0, 0, '0);
    vec[5]  = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  1,  0, 1, 16'h1230, DA5, 1, 0, '0);   // resp -> ack
    vec[6]  = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 0, 16'h1230, DA5, 0, 0, '0);   // IDLE
    vec[7]  = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  1,  0, 0, 16'h1230, DA5, 0, 0, '0);   // stray resp
    vec[8]  = mk(0, 0, 16'h0000, '0,  1, 16'h4560, '0,  0,  0, 0, 16'h1230, DA5, 0, 0, '0);   // L2 req seen
    vec[9]  = mk(0, 0, 16'h0000, '0,  1, 16'h4560, '0,  0,  1, 0, 16'h4560, DA5, 0, 0, '0);   // L2 granted
    vec[10] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, DDB, 1,  1, 0, 16'h4560, DA5, 0, 1, DDB);  // fill
    vec[11] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 0, 16'h4560, DA5, 0, 0, DDB);  // data held
    vec[12] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  0,  0, 0, 16'h4560, DA5, 0, 0, DDB);  // both, streak 0
    vec[13] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  1,  0, 1, 16'h0A00, W1,  1, 0, DDB);  // VC #1
    vec[14] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  0,  0, 0, 16'h0A00, W1,  0, 0, DDB);  // IDLE gap
    vec[15] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  1,  0, 1, 16'h0A00, W1,  1, 0, DDB);  // VC #2
    vec[16] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  0,  0, 0, 16'h0A00, W1,  0, 0, DDB);  // IDLE gap
    vec[17] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, R2,  1,  1, 0, 16'h0B00, W1,  0, 1, R2);   // L2 wins
    vec[18] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  0,  0, 0, 16'h0B00, W1,  0, 0, R2);   // IDLE gap
    vec[19] = mk(0, 1, 16'h0A00, W1,  1, 16'h0B00, '0,  1,  0, 1, 16'h0A00, W1,  1, 0, R2);   // VC again
    vec[20] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 0, 16'h0A00, W1,  0, 0, R2);
    vec[21] = mk(0, 1, 16'h3330, W2,  0, 16'h0000, '0,  0,  0, 0, 16'h0A00, W1,  0, 0, R2);   // VC req
    vec[22] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 1, 16'h3330, W2,  0, 0, R2);   // dropped, continues
    vec[23] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  1,  0, 1, 16'h3330, W2,  1, 0, R2);
    vec[24] = mk(0, 0, 16'h0000, '0,  0, 16'h0000, '0,  0,  0, 0, 16'h3330, W2,  0, 0, R2);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vec[i]);
      #3;
      check_outputs(vec[i], i);
    end

    // Reset in the middle of a write-back, then a late pmem_resp.
    @(posedge clk);
    #1;
    vc_req     = 1'b1;
    vc_address = 16'h7770;
    vc_wdata   = W2;
    @(posedge clk);
    #1;
    chk("rst_pre_write", 100, 128'(pmem_write), 128'(1'b1));
    chk("rst_pre_addr",  100, 128'(pmem_address), 128'(16'h7770));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_write", 101, 128'(pmem_write),   128'(1'b0));
    chk("rst_async_addr",  101, 128'(pmem_address), 128'(16'h0000));
    chk("rst_async_wdata", 101, pmem_wdata,         128'(0));
    chk("rst_async_rdata", 101, l2_mem_rdata,       128'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    vc_req    = 1'b0;
    pmem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_vc_ack", 102 + k, 128'(vc_mem_ack), 128'(1'b0));
      chk("post_rst_l2_ack", 102 + k, 128'(l2_mem_ack), 128'(1'b0));
      chk("post_rst_write",  102 + k, 128'(pmem_write), 128'(1'b0));
      chk("post_rst_read",   102 + k, 128'(pmem_read),  128'(1'b0));
    end
    pmem_resp = 1'b0;

    // After reset the streak is clear: simultaneous requests grant VC first.
    @(posedge clk);
    #1;
    vc_req      = 1'b1;
    vc_address  = 16'h5550;
    vc_wdata    = W1;
    l2_mem_read = 1'b1;
    l2_address  = 16'h6660;
    @(posedge clk);
    #1;
    chk("post_rst_grant_vc", 110, 128'(pmem_write),   128'(1'b1));
    chk("post_rst_grant_ad", 110, 128'(pmem_address), 128'(16'h5550));
    vc_req      = 1'b0;
    l2_mem_read = 1'b0;
    pmem_resp   = 1'b1;
    #1;
    chk("post_rst_vc_ack_ok", 111, 128'(vc_mem_ack), 128'(1'b1));
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    chk("post_rst_idle", 112, 128'(pmem_write), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
